// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: clocked front end for a combinational ALU.
// Accepts opcode/operand commands over valid/ready, holds them on the ALU
// inputs for SETTLE cycles, then captures result and flags and returns them
// over a valid/ready response channel. Counts completed responses.
// Optional: define ALU_OPCODE_CHECK_EN to short-circuit unused opcodes
// (6, 7, 12-15) straight to an error response without touching the ALU.
module alu_op_sequencer #(
   parameter int N      = 3,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   // command channel
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [3:0]       cmd_op_i,
   input  logic [N-1:0]     cmd_a_i,
   input  logic [N-1:0]     cmd_b_i,
   // ALU interface
   output logic [N-1:0]     alu_a_o,
   output logic [N-1:0]     alu_b_o,
   output logic [3:0]       alu_s_o,
   input  logic [N-1:0]     alu_c_i,
   input  logic             alu_zero_i,
   input  logic             alu_negative_i,
   input  logic             alu_carry_i,
   input  logic             alu_overflow_i,
   // response channel
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [N-1:0]     rsp_result_o,
   output logic [3:0]       rsp_flags_o,
   output logic             rsp_err_o,
   // status
   output logic             busy_o,
   output logic [CNT_W-1:0] op_count_o
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     alu_a_q, alu_a_d;
   logic [N-1:0]     alu_b_q, alu_b_d;
   logic [3:0]       alu_s_q, alu_s_d;
   logic [N-1:0]     rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic             rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

`ifdef ALU_OPCODE_CHECK_EN
   logic op_illegal;
   assign op_illegal = cmd_op_i inside {4'd6, 4'd7, [4'd12:4'd15]};
`endif

   // Next-state and datapath updates for the command/settle/response sequence.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_s_d      = alu_s_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_err_d    = rsp_err_q;
      op_count_d   = op_count_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
`ifdef ALU_OPCODE_CHECK_EN
               if (op_illegal) begin
                  // Unused opcode: ALU inputs untouched, immediate error response.
                  rsp_result_d = '0;
                  rsp_flags_d  = 4'b0000;
                  rsp_err_d    = 1'b1;
                  state_d      = RESP;
               end else begin
                  alu_a_d = cmd_a_i;
                  alu_b_d = cmd_b_i;
                  alu_s_d = cmd_op_i;
                  cnt_d   = CW'(SETTLE - 1);
                  state_d = DRIVE;
               end
`else
               alu_a_d = cmd_a_i;
               alu_b_d = cmd_b_i;
               alu_s_d = cmd_op_i;
               cnt_d   = CW'(SETTLE - 1);
               state_d = DRIVE;
`endif
            end
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               // Inputs have been stable for SETTLE cycles: sample the ALU.
               rsp_result_d = alu_c_i;
               rsp_flags_d  = {alu_zero_i, alu_negative_i, alu_carry_i, alu_overflow_i};
               rsp_err_d    = 1'b0;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               op_count_d = op_count_q + CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_s_q      <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_s_q      <= alu_s_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_err_q    <= rsp_err_d;
         op_count_q   <= op_count_d;
      end
   end

   assign cmd_ready_o  = (state_q == IDLE);
   assign rsp_valid_o  = (state_q == RESP);
   assign busy_o       = (state_q != IDLE);
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_s_o      = alu_s_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_flags_o  = rsp_flags_q;
   assign rsp_err_o    = rsp_err_q;
   assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a transaction-level reference
// model predicts every output each cycle; directed sequences pin latency,
// capture timing, backpressure, counter wrap, reset abandonment and the
// unused-opcode behaviour, followed by randomized traffic.
module tb_alu_op_sequencer;

   localparam int N      = 4;
   localparam int S      = 3;
   localparam int CNT_W  = 2;
`ifdef ALU_OPCODE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_ready;
   logic [3:0]       cmd_op;
   logic [N-1:0]     cmd_a, cmd_b;
   logic [N-1:0]     alu_a, alu_b, alu_c;
   logic [3:0]       alu_s;
   logic             alu_zero, alu_negative, alu_carry, alu_overflow;
   logic             rsp_valid, rsp_ready, rsp_err, busy;
   logic [N-1:0]     rsp_result;
   logic [3:0]       rsp_flags;
   logic [CNT_W-1:0] op_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.N(N), .SETTLE(S), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_s_o(alu_s), .alu_c_i(alu_c),
      .alu_zero_i(alu_zero), .alu_negative_i(alu_negative),
      .alu_carry_i(alu_carry), .alu_overflow_i(alu_overflow),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err),
      .busy_o(busy), .op_count_o(op_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Bench ALU: returns {c, zero, negative, carry, overflow}.
   function automatic logic [N+3:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0]   w;
      logic [N-1:0] c;
      logic         cy, ov;
      int           sh;
      cy = 1'b0; ov = 1'b0; c = '0; w = '0;
      sh = int'(b) % N;
      case (op)
         4'd0:  c = a & b;
         4'd1:  c = a | b;
         4'd2:  c = a ^ b;
         4'd3:  c = a << sh;
         4'd4:  c = a >> sh;
         4'd5:  c = (a << sh) | (a >> (N - sh));
         4'd8:  begin
            w = {1'b0, a} + {1'b0, b}; c = w[N-1:0]; cy = w[N];
            ov = (a[N-1] == b[N-1]) && (c[N-1] != a[N-1]);
         end
         4'd9:  begin
            w = {1'b0, a} - {1'b0, b}; c = w[N-1:0]; cy = w[N];
            ov = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]);
         end
         4'd10: c = a << sh;
         4'd11: c = $signed(a) >>> sh;
         default: c = '0;
      endcase
      return {c, (c == '0), c[N-1], cy, ov};
   endfunction

   function automatic bit illegal(input logic [3:0] op);
      return op inside {4'd6, 4'd7, [4'd12:4'd15]};
   endfunction

   // ALU driver: real ALU on the DUT's registered inputs, or a per-cycle
   // pattern (cycle j drives j) to expose the exact capture edge.
   logic [31:0]  edge_cnt = 0;
   logic         cnt_mode = 1'b0;
   logic [N+3:0] fn_out;
   logic [31:0]  pat_flags;
   assign fn_out    = alu_fn(alu_s, alu_a, alu_b);
   assign pat_flags = edge_cnt * 7 + 1;
   assign alu_c     = cnt_mode ? edge_cnt[N-1:0] : fn_out[N+3:4];
   assign {alu_zero, alu_negative, alu_carry, alu_overflow} = cnt_mode ? pat_flags[3:0] : fn_out[3:0];

   // Reference model: one outstanding transaction, described by the cycle
   // its response becomes visible and the values it will show.
   bit           started = 0;
   bit           m_busy = 0;
   int           m_valid_from = 0;
   int           m_count = 0;
   logic [N-1:0] m_a = '0, m_b = '0, m_result = '0, p_result = '0;
   logic [3:0]   m_s = '0, m_flags = '0, p_flags = '0;
   logic         m_err = 1'b0, p_err = 1'b0;

   always @(posedge clk) begin
      int           e;
      logic [31:0]  j, jf;
      logic [N+3:0] r;
      edge_cnt <= edge_cnt + 1;
      e = int'(edge_cnt);
      if (rst) begin
         started = 1; m_busy = 0; m_count = 0;
         m_a = '0; m_b = '0; m_s = '0; m_result = '0; m_flags = '0; m_err = 1'b0;
      end else begin
         if (m_busy && e >= m_valid_from && rsp_ready) begin
            m_busy = 0;
            m_count++;
         end else if (!m_busy && cmd_valid) begin
            m_busy = 1;
            if (CHK && illegal(cmd_op)) begin
               m_valid_from = e + 1;
               p_result = '0; p_flags = '0; p_err = 1'b1;
            end else begin
               m_a = cmd_a; m_b = cmd_b; m_s = cmd_op;
               m_valid_from = e + S + 1;
               if (cnt_mode) begin
                  j  = edge_cnt + S;
                  jf = j * 7 + 1;
                  p_result = j[N-1:0]; p_flags = jf[3:0];
               end else begin
                  r = alu_fn(cmd_op, cmd_a, cmd_b);
                  p_result = r[N+3:4]; p_flags = r[3:0];
               end
               p_err = 1'b0;
            end
         end
         if (m_busy && e + 1 == m_valid_from) begin
            m_result = p_result; m_flags = p_flags; m_err = p_err;
         end
      end
   end

   // Compare process: every output, every cycle after the first reset edge.
   always @(negedge clk) begin
      if (started) begin
         check("m_cmd_ready", 32'(cmd_ready), 32'(!m_busy));
         check("m_busy", 32'(busy), 32'(m_busy));
         check("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && int'(edge_cnt) >= m_valid_from));
         check("m_alu_a", 32'(alu_a), 32'(m_a));
         check("m_alu_b", 32'(alu_b), 32'(m_b));
         check("m_alu_s", 32'(alu_s), 32'(m_s));
         check("m_rsp_result", 32'(rsp_result), 32'(m_result));
         check("m_rsp_flags", 32'(rsp_flags), 32'(m_flags));
         check("m_rsp_err", 32'(rsp_err), 32'(m_err));
         check("m_op_count", 32'(op_count), 32'(m_count % (1 << CNT_W)));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one command for exactly one cycle (DUT must be idle), then wait
   // for the response; returns cycles from accept edge to first rsp_valid.
   task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      tick();
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 50) begin
         tick();
         lat++;
      end
      if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      int           lat, k, seen;
      logic [31:0]  jexp, fexp;
      logic [N+3:0] r;
      logic [CNT_W-1:0] last;
      logic [CNT_W-1:0] wrap_got [5];
      logic [CNT_W-1:0] wrap_exp [5];

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_alu_s", 32'(alu_s), 32'd0);
      check("reset_op_count", 32'(op_count), 32'd0);

      // Pin the bench ALU: 3+5 in 4 bits = 8, negative and signed overflow.
      r = alu_fn(4'd8, 4'd3, 4'd5);
      check("pin_alu_add", 32'(r), {24'd0, 4'h8, 4'b0101});

      // Latency: accept at edge k, alu_s in k+1, rsp_valid first in k+S+1.
      cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 4'd3; cmd_b = 4'd5;
      tick();
      cmd_valid = 1'b0;
      check("lat_alu_s", 32'(alu_s), 32'd8);
      check("lat_no_valid_k1", 32'(rsp_valid), 32'd0);
      repeat (S - 1) tick();
      check("lat_no_valid_kS", 32'(rsp_valid), 32'd0);
      tick();
      check("lat_valid", 32'(rsp_valid), 32'd1);
      check("lat_result", 32'(rsp_result), 32'h8);
      check("lat_flags", 32'(rsp_flags), 32'b0101);
      tick();
      check("lat_op_count", 32'(op_count), 32'd1);
      check("lat_ready_again", 32'(cmd_ready), 32'd1);

      // Capture timing with a per-cycle ALU pattern.
      cnt_mode = 1'b1;
      k = int'(edge_cnt);
      issue(4'd0, 4'd1, 4'd2, lat);
      jexp = 32'(k + S);
      fexp = jexp * 7 + 1;
      check("cap_latency", 32'(lat), 32'(S + 1));
      check("cap_result", 32'(rsp_result), {28'd0, jexp[3:0]});
      check("cap_flags", 32'(rsp_flags), {28'd0, fexp[3:0]});
      tick();
      cnt_mode = 1'b0;

      // Backpressure: response held, new commands ignored.
      rsp_ready = 1'b0;
      issue(4'd9, 4'd2, 4'd7, lat);
      r = alu_fn(4'd9, 4'd2, 4'd7);
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_op = 4'(i); cmd_a = 4'(i + 5); cmd_b = 4'(i + 9);
         tick();
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_result", 32'(rsp_result), 32'(r[N+3:4]));
         check("bp_flags", 32'(rsp_flags), 32'(r[3:0]));
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_alu_a", 32'(alu_a), 32'd2);
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      tick();
      check("bp_released_valid", 32'(rsp_valid), 32'd0);
      check("bp_released_ready", 32'(cmd_ready), 32'd1);
      check("bp_released_busy", 32'(busy), 32'd0);

      // Reset mid-DRIVE abandons the command.
      cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 4'd6; cmd_b = 4'd9;
      tick();
      cmd_valid = 1'b0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_alu_a", 32'(alu_a), 32'd0);
      check("rstmid_alu_s", 32'(alu_s), 32'd0);
      check("rstmid_result", 32'(rsp_result), 32'd0);
      check("rstmid_op_count", 32'(op_count), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Counter wrap: 5 back-to-back operations, op_count 1,2,3,0,1.
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
      seen = 0; last = op_count;
      cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 4'd5; cmd_b = 4'd3;
      for (int i = 0; i < 100 && seen < 5; i++) begin
         tick();
         if (op_count !== last) begin
            wrap_got[seen] = op_count;
            last = op_count;
            seen++;
         end
      end
      cmd_valid = 1'b0;
      check("wrap_seen", 32'(seen), 32'd5);
      for (int i = 0; i < seen; i++) check("wrap_value", 32'(wrap_got[i]), 32'(wrap_exp[i]));
      while (busy) tick();

      // Unused opcode 13 after a legal XOR.
      issue(4'd2, 4'd12, 4'd10, lat);
      tick();
      issue(4'd13, 4'd7, 4'd1, lat);
      check("op13_latency", 32'(lat), CHK ? 32'd1 : 32'(S + 1));
      check("op13_err", 32'(rsp_err), 32'(CHK));
      check("op13_result", 32'(rsp_result), 32'd0);
      check("op13_flags", 32'(rsp_flags), CHK ? 32'd0 : 32'b1000);
      check("op13_alu_s", 32'(alu_s), CHK ? 32'd2 : 32'd13);
      check("op13_alu_a", 32'(alu_a), CHK ? 32'd12 : 32'd7);
      tick();

      // Randomized traffic checked by the model.
      for (int i = 0; i < 400; i++) begin
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = 4'($urandom);
         cmd_a     = N'($urandom);
         cmd_b     = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      repeat (S + 3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side front end for the parameterized combinational ALU. It accepts operation commands over a valid/ready handshake and drives the ALU operand and opcode inputs from registers. After a fixed settle time it captures the ALU result and its four flags, then returns them over a valid/ready response channel. It sits between control logic (or a bench) and the ALU, so the combinational ALU can be used in a clocked pipeline.

Parameters:
N, 3, data width; must match the ALU operand/result width (N >= 2).
SETTLE, 1, cycles the ALU inputs are held before capture (>= 1).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  4  ALU opcode
cmd_a  in  N  operand a
cmd_b  in  N  operand b
alu_a  out  N  registered operand a to ALU
alu_b  out  N  registered operand b to ALU
alu_s  out  4  registered opcode to ALU
alu_c  in  N  ALU result
alu_zero  in  1  ALU zero flag
alu_negative  in  1  ALU negative flag
alu_carry  in  1  ALU carry flag
alu_overflow  in  1  ALU overflow flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  N  captured result
rsp_flags  out  4  captured flags: [3]=zero, [2]=negative, [1]=carry, [0]=overflow
rsp_err  out  1  illegal-opcode response (see Optional Feature)
busy  out  1  high in DRIVE or RESP
op_count  out  CNT_W  completed response handshakes

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; alu_a, alu_b, alu_s, rsp_result, rsp_flags = 0.
  - rsp_valid, rsp_err, busy = 0; op_count = 0.
- Reset mid-operation: the in-flight command is abandoned and no response is produced.
- States: IDLE, DRIVE, RESP.
- cmd_ready = (state==IDLE), purely from state. No combinational path from cmd_valid or rsp_ready to cmd_ready.
- IDLE:
  - on cmd_valid&&cmd_ready at edge k, register cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_s.
  - load the settle counter with SETTLE-1; go to DRIVE.
- DRIVE:
  - alu_* are stable from cycle k+1.
  - the counter decrements each cycle; at the edge ending cycle k+SETTLE, register alu_c into rsp_result and {alu_zero,alu_negative,alu_carry,alu_overflow} into rsp_flags.
  - set rsp_valid and go to RESP.
  - Latency: rsp_valid is first high in cycle k+SETTLE+1.
- RESP:
  - rsp_result, rsp_flags and rsp_err are held stable while rsp_valid && !rsp_ready.
  - on rsp_valid&&rsp_ready: clear rsp_valid, op_count += 1, go to IDLE.
  - the next command can be accepted one cycle after the response handshake.
- alu_a/alu_b/alu_s hold their last values in IDLE and RESP; they change only on command accept.
- rsp_result/rsp_flags keep their last captured values after the handshake.
- op_count wraps from 2^CNT_W-1 to 0 with no status change.
- cmd_valid while not ready: no effect; the command must be held by the initiator.
- Opcodes are passed through unchanged. The ALU defines 0 AND, 1 OR, 2 XOR, 3 logical left shift, 4 logical right shift, 5 circular shift, 8 add, 9 subtract, 10 arithmetic left shift, 11 arithmetic right shift. Codes 6, 7 and 12-15 are unused and return 0.

Optional Feature:
Macro ALU_OPCODE_CHECK_EN.
- Defined:
  - an accepted command with cmd_op in {6,7,12,13,14,15} does not update alu_a/alu_b/alu_s.
  - the FSM goes directly from IDLE to RESP with rsp_result=0, rsp_flags=4'b0000, rsp_err=1; rsp_valid is first high in cycle k+1.
  - legal opcodes set rsp_err=0.
- Not defined:
  - all opcodes take the DRIVE path.
  - rsp_err is constant 0.

Test Plan:
- Reset: assert rst 2 cycles mid-DRIVE -> all outputs 0, cmd_ready=1 next cycle, no rsp_valid ever produced for the abandoned command.
- Latency, N=4, SETTLE=1, rsp_ready=1, real ALU: cmd_op=8, a=4'd3, b=4'd5, accept at edge 0 -> alu_s=8 in cycle 1, rsp_valid in cycle 2, rsp_result=4'h8, op_count=1 after handshake.
- Capture timing, SETTLE=3, bench ALU model changes alu_c each cycle (cycle j drives j[N-1:0]) -> rsp_result equals the value driven in cycle k+3; flags captured in [3:0] order.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, busy=1, cmd_valid ignored; release -> one handshake, IDLE next cycle.
- Counter wrap, CNT_W=2: 5 back-to-back operations -> op_count sequence 1,2,3,0,1.
- With ALU_OPCODE_CHECK_EN: cmd_op=4'd13 -> rsp_valid at k+1, rsp_err=1, result/flags 0, alu_* unchanged. Without the macro: the same opcode takes SETTLE+1 cycles, rsp_err=0, result 0.
